mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 10, byte-address width shared by requesters and memory port.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch request (always word read).
REQ-005 if_addr  input  ADDR_W  fetch byte address.
REQ-006 if_ack  output  1  one-cycle completion pulse for fetch.
REQ-007 if_rdata  output  32  fetched word; valid while if_ack=1.
REQ-008 d_req  input  1  data request.
REQ-009 d_we  input  1  1=store, 0=load.
REQ-010 d_byte  input  1  1=byte access, 0=word access.
REQ-011 d_addr  input  ADDR_W  data byte address.
REQ-012 d_wdata  input  32  store data; byte store uses bits [7:0].
REQ-013 d_ack  output  1  one-cycle completion pulse for data.
REQ-014 d_rdata  output  32  load result; valid while d_ack=1.
REQ-015 mem_address  output  ADDR_W  byte address to shared memory.
REQ-016 mem_write  output  1  memory write strobe (writes 4 bytes at mem_address..+3).
REQ-017 mem_writedata  output  32  memory write data.
REQ-018 mem_readword  input  32  memory read word, registered by memory one edge after address.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR.
REQ-021 Requests are sampled only in IDLE; at sampling edge E the winner's address, data and kind are latched and the FSM leaves IDLE.
REQ-022 Word read (fetch, or load of either size): IDLE->RD at E, RD->RD_WAIT at E+1, RD_WAIT->IDLE at E+2 with ack=1 and rdata registered from mem_readword; ack visible the cycle after E+2.
REQ-023 Byte load returns {24'h0, mem_readword[7:0]} (byte at d_addr, zero-extended).
REQ-024 Word store: IDLE->WR at E; mem_write=1 during WR; WR->IDLE at E+1 with ack=1.
REQ-025 Byte store (read-modify-write): IDLE->RMW_RD at E, ->RMW_WAIT at E+1, ->RMW_WR at E+2 latching {mem_readword[31:8], d_wdata[7:0]}; mem_write=1 during RMW_WR; ->IDLE at E+3 with ack=1.
REQ-026 mem_address equals the latched address in every non-IDLE state; mem_write=0 in all other states and whenever reset=1.
REQ-027 ack is a single-cycle pulse; the requester deasserts req or presents a new request in the ack cycle; req still high at the next IDLE sample is a new request.
REQ-028 Address wrap: latched address plus byte offsets are computed modulo 2^ADDR_W; no range check.
REQ-029 Simultaneous if_req and d_req in IDLE: winner per REQ-033; loser stays pending and is served in the next IDLE sample.
REQ-030 Only the granted requester's ack and rdata change; the other's rdata holds.

Reset
REQ-031 Reset at any edge forces IDLE, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, busy=0, round-robin pointer to "last=IF"; an in-flight transaction is abandoned without ack.
REQ-032 Reset mid-RMW suppresses the write-back (mem_write=0 during the reset cycle).

Configuration
REQ-033 MEM_ARB_RR_EN defined: round-robin; on a tie the requester not granted last wins, pointer updates on each grant. Undefined: fixed priority, data always wins ties; no pointer state.

Verification
REQ-034 Word store d_addr=0x010, d_wdata=0xDEADBEEF, then word load 0x010 -> d_ack one cycle after E+1, load d_rdata=0xDEADBEEF after E+2.
REQ-035 Byte store 0x5A to 0x011 over word 0xDEADBEEF at 0x010, then word load 0x010 -> 0xDEAD5AEF; byte-store d_ack after E+3.
REQ-036 if_req and d_req both high from reset, both held for 4 transactions -> fixed: D,D,D,D with IF starved; RR_EN: D,IF,D,IF.
REQ-037 Reset asserted in RMW_WAIT of byte store to 0x020 -> no d_ack, mem_write never 1, word at 0x020 unchanged.
REQ-038 Fetch at if_addr=0x3FC after word store 0x11223344 there -> if_rdata=0x11223344, bytes 0x3FC..0x3FF written, if_ack one pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto one shared synchronous memory port,
// with byte stores done as read-modify-write. Define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readword,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              src_d_q;
    logic              byte_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              pick_data;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;  // 1 = data was granted last; reset value means "last=IF"

    always_comb begin
        pick_data = d_req;
        if (d_req && if_req) pick_data = !last_d_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else if (state_q == IDLE && (if_req || d_req)) begin
            last_d_q <= pick_data;
        end
    end
`else
    assign pick_data = d_req;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            src_d_q    <= 1'b0;
            byte_q     <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        src_d_q <= pick_data;
                        if (pick_data) begin
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                            byte_q  <= d_byte;
                            if (!d_we)       state_q <= RD;
                            else if (d_byte) state_q <= RMW_RD;
                            else             state_q <= WR;
                        end else begin
                            addr_q  <= if_addr;
                            byte_q  <= 1'b0;
                            state_q <= RD;
                        end
                    end
                end
                RD:      state_q <= RD_WAIT;
                RD_WAIT: begin
                    state_q <= IDLE;
                    if (src_d_q) begin
                        d_ack_q   <= 1'b1;
                        d_rdata_q <= byte_q ? {24'h0, mem_readword[7:0]} : mem_readword;
                    end else begin
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= mem_readword;
                    end
                end
                WR: begin
                    state_q <= IDLE;
                    d_ack_q <= 1'b1;
                end
                RMW_RD:   state_q <= RMW_WAIT;
                RMW_WAIT: begin
                    // Keep the upper three bytes of the addressed word, replace the low one.
                    wdata_q <= {mem_readword[31:8], wdata_q[7:0]};
                    state_q <= RMW_WR;
                end
                RMW_WR: begin
                    state_q <= IDLE;
                    d_ack_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign mem_write     = (state_q == WR || state_q == RMW_WR) && !reset;
    assign busy          = (state_q != IDLE);
    assign if_ack        = if_ack_q;
    assign d_ack         = d_ack_q;
    assign if_rdata      = if_rdata_q;
    assign d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected acks, a monitor pops
// and compares port, data and ack cycle. Honours MEM_ARB_RR_EN for the tie-break sequence.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, d_byte;
    logic [9:0]  if_addr, d_addr;
    logic [31:0] d_wdata;
    logic        if_ack, d_ack, mem_write, busy;
    logic [31:0] if_rdata, d_rdata, mem_writedata;
    logic [31:0] mem_readword;
    logic [9:0]  mem_address;

    mem_arbiter #(.ADDR_W(10)) dut (
        .clock(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_readword(mem_readword), .busy(busy)
    );

    always #5 clk = ~clk;

    // Byte-addressed little-endian memory, registered read, wraps modulo 1024.
    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        mem_readword <= {mem[10'(mem_address + 10'd3)], mem[10'(mem_address + 10'd2)],
                         mem[10'(mem_address + 10'd1)], mem[mem_address]};
        if (mem_write) begin
            for (int i = 0; i < 4; i++) mem[10'(mem_address + 10'(i))] <= mem_writedata[8*i +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        bit          chk;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] hold_if = '0;
    logic [31:0] hold_d  = '0;
    bit          mw_watch = 1'b0;
    bit          mw_seen  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (mw_watch && mem_write) mw_seen = 1'b1;
        if (if_ack && d_ack) begin
            tests++; fails++;
            $display("FAIL both_ack: got if_ack=1 d_ack=1 expected one at a time (cycle %0d)", cyc);
        end else if (if_ack || d_ack) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b expected none (cycle %0d)",
                         if_ack, d_ack, cyc);
            end else begin
                e = sb.pop_front();
                chk("ack_port_is_d", {31'b0, d_ack}, {31'b0, e.is_d});
                chk("ack_cycle", cyc, e.cyc);
                if (d_ack) begin
                    if (e.chk) begin
                        chk("d_rdata", d_rdata, e.data);
                        hold_d = e.data;
                    end
                    chk("if_rdata_hold", if_rdata, hold_if);
                end else begin
                    chk("if_rdata", if_rdata, e.data);
                    hold_if = e.data;
                    chk("d_rdata_hold", d_rdata, hold_d);
                end
                $display("[TB] ack %s cycle=%0d if_rdata=%h d_rdata=%h",
                         d_ack ? "D " : "IF", cyc, if_rdata, d_rdata);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL ack_timeout: got %0d pending acks expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input bit is_d, input bit we, input bit byt, input logic [9:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp, input bit chkd);
        exp_t e;
        int   lat;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_byte = byt; d_addr = addr; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        lat    = (!is_d || !we) ? 2 : (byt ? 3 : 1);
        e.is_d = is_d; e.chk = chkd; e.data = exp; e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        d_req = 1'b0; if_req = 1'b0;
        drain();
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        exp_t e;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_if_ack", {31'b0, if_ack}, 32'd0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        reset = 1'b0;

        // Word store then load; byte-store RMW merge; byte loads.
        issue(1, 1, 0, 10'h010, 32'hDEADBEEF, 32'h0, 0);
        issue(1, 0, 0, 10'h010, 32'h0, 32'hDEADBEEF, 1);
        issue(1, 1, 1, 10'h011, 32'h0000005A, 32'h0, 0);
        issue(1, 0, 0, 10'h010, 32'h0, 32'hDEAD5AEF, 1);
        issue(1, 0, 1, 10'h011, 32'h0, 32'h0000005A, 1);
        issue(1, 0, 1, 10'h013, 32'h0, 32'h000000DE, 1);

        // Top-of-memory word, then fetch it; byte store at 0x3FF wraps to 0x000..0x002.
        issue(1, 1, 0, 10'h3FC, 32'h11223344, 32'h0, 0);
        issue(0, 0, 0, 10'h3FC, 32'h0, 32'h11223344, 1);
        chk("mem_3FC", {24'h0, mem[10'h3FC]}, 32'h44);
        chk("mem_3FD", {24'h0, mem[10'h3FD]}, 32'h33);
        chk("mem_3FE", {24'h0, mem[10'h3FE]}, 32'h22);
        chk("mem_3FF", {24'h0, mem[10'h3FF]}, 32'h11);
        issue(1, 1, 1, 10'h3FF, 32'hFFFFFF77, 32'h0, 0);
        issue(1, 0, 1, 10'h3FF, 32'h0, 32'h00000077, 1);
        issue(0, 0, 0, 10'h3FC, 32'h0, 32'h77223344, 1);
        chk("mem_000_wrap", {24'h0, mem[10'h000]}, 32'h00);

        // Reset in RMW_WAIT abandons the byte store with no write-back and no ack.
        issue(1, 1, 0, 10'h020, 32'hCAFEF00D, 32'h0, 0);
        mw_seen = 1'b0; mw_watch = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 10'h020; d_wdata = 32'h00000099;
        @(negedge clk);
        d_req = 1'b0;
        chk("rmw_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1; hold_if = '0; hold_d = '0;
        #1;
        chk("rst_cycle_mem_write", {31'b0, mem_write}, 32'd0);
        @(negedge clk);
        chk("rst_abort_busy", {31'b0, busy}, 32'd0);
        chk("rst_abort_d_rdata", d_rdata, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        mw_watch = 1'b0;
        chk("rst_abort_no_write", {31'b0, mw_seen}, 32'd0);
        chk("mem_020_word", {mem[10'h023], mem[10'h022], mem[10'h021], mem[10'h020]}, 32'hCAFEF00D);
        issue(1, 0, 0, 10'h020, 32'h0, 32'hCAFEF00D, 1);

        // Both requesters held high from reset for four back-to-back reads.
        @(negedge clk);
        reset = 1'b1; hold_if = '0; hold_d = '0;
        if_req = 1'b1; if_addr = 10'h3FC;
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 10'h010;
        @(negedge clk);
        reset = 1'b0;
        e0 = cyc + 1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            e.is_d = (k % 2 == 0);
`else
            e.is_d = 1'b1;
`endif
            e.chk  = 1'b1;
            e.data = e.is_d ? 32'hDEAD5AEF : 32'h77223344;
            e.cyc  = e0 + 3 * k + 2;
            sb.push_back(e);
        end
        for (int n = 0; n < 40 && cyc < e0 + 11; n++) @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        drain();
`ifndef MEM_ARB_RR_EN
        chk("starved_if_rdata", if_rdata, 32'd0);
`endif
        repeat (4) @(negedge clk);
        chk("final_busy", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
